// File: rtl/fc_seq_pkg.sv
// Shared types and width helpers for the fully-connected layer sequencer.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLR   = 3'd1,
    COMP  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_e;

  // Bits needed to hold a counter ranging over 0..n-1 (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // x RAM address width for an n-word input vector.
  function automatic int vec_addr_bits(input int n);
    return cnt_bits(n);
  endfunction

  // Weight ROM address width: each ROM holds (m/p) rows of n weights.
  function automatic int mat_addr_bits(input int m, input int n, input int p);
    return cnt_bits((m * n) / p);
  endfunction

  // Group counter width: m/p groups of p neurons each.
  function automatic int group_bits(input int m, input int p);
    return cnt_bits(m / p);
  endfunction

endpackage

// File: rtl/fc_seq_delay.sv
// Fixed-depth 1-bit delay line: turns the address-issue strobe into en_acc
// once the datapath read pipeline has produced the matching product.
module fc_seq_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH:0] tap;

  assign tap[0] = din;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic q_reg;

    // One pipeline stage; reset flushes any in-flight tokens.
    always_ff @(posedge clk) begin
      if (reset) q_reg <= 1'b0;
      else       q_reg <= tap[gi];
    end

    assign tap[gi+1] = q_reg;
  end

  assign dout = tap[DEPTH];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Control FSM for one fully-connected layer: load x, then per group
// clear / compute / drain / stream P results. Carries no data bits.
// Optional build macro FC_SEQ_PERF_EN adds stall_cycles and layer_done outputs.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int M        = 10,
  parameter int N        = 8,
  parameter int T        = 16,
  parameter int P        = 1,
  parameter int PIPE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      input_valid,
  output logic                      input_ready,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [$clog2(N)-1:0]      addr_x,
  output logic                      wr_en_x,
  output logic [$clog2(M*N/P)-1:0]  addr_w,
  output logic                      wr_en_w,
  output logic                      clear_acc,
  output logic                      en_acc,
  output logic [P-1:0]              f_sel
`ifdef FC_SEQ_PERF_EN
  ,
  output logic [15:0]               stall_cycles,
  output logic                      layer_done
`endif
);

  localparam int XW     = vec_addr_bits(N);
  localparam int WW     = mat_addr_bits(M, N, P);
  localparam int GROUPS = M / P;
  localparam int GW     = group_bits(M, P);
  localparam int JW     = cnt_bits(P);
  localparam int DW     = cnt_bits(PIPE_LAT);

  if (M % P != 0) begin : g_bad_mp
    $error("fc_layer_sequencer: M must be a multiple of P");
  end
  if (N < 2) begin : g_bad_n
    $error("fc_layer_sequencer: N must be at least 2");
  end
  if (PIPE_LAT < 1) begin : g_bad_lat
    $error("fc_layer_sequencer: PIPE_LAT must be at least 1");
  end
  if (T < 1) begin : g_bad_t
    $error("fc_layer_sequencer: T must be at least 1");
  end

  state_e         state_reg, state_next;
  logic [XW-1:0]  i_reg;   // load index
  logic [XW-1:0]  k_reg;   // MAC index within a group
  logic [DW-1:0]  d_reg;   // drain cycle index
  logic [GW-1:0]  g_reg;   // group index
  logic [JW-1:0]  j_reg;   // output lane index
  logic           last_i, last_k, last_d, last_group, last_lane, issue;

  assign last_i     = (i_reg == XW'(N - 1));
  assign last_k     = (k_reg == XW'(N - 1));
  assign last_d     = (d_reg == DW'(PIPE_LAT - 1));
  assign last_group = (g_reg == GW'(GROUPS - 1));
  assign last_lane  = (j_reg == JW'(P - 1));
  assign issue      = (state_reg == COMP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= LOAD;
    else       state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (input_valid && last_i) state_next = CLR;
      CLR:     state_next = COMP;
      COMP:    if (last_k) state_next = DRAIN;
      DRAIN:   if (last_d) state_next = OUT;
      OUT:     if (output_ready && last_lane) state_next = last_group ? LOAD : CLR;
      default: state_next = LOAD;
    endcase
  end

  // Layer counters; each returns to zero at the end of its own range.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_reg <= '0;
      k_reg <= '0;
      d_reg <= '0;
      g_reg <= '0;
      j_reg <= '0;
    end else begin
      case (state_reg)
        LOAD:  if (input_valid) i_reg <= last_i ? '0 : i_reg + XW'(1);
        COMP:  k_reg <= last_k ? '0 : k_reg + XW'(1);
        DRAIN: d_reg <= last_d ? '0 : d_reg + DW'(1);
        OUT: begin
          if (output_ready) begin
            if (last_lane) begin
              j_reg <= '0;
              g_reg <= last_group ? '0 : g_reg + GW'(1);
            end else begin
              j_reg <= j_reg + JW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath control pins decoded from state and counters.
  always_comb begin
    input_ready  = 1'b0;
    output_valid = 1'b0;
    wr_en_x      = 1'b0;
    wr_en_w      = 1'b0;
    clear_acc    = 1'b0;
    addr_x       = '0;
    addr_w       = '0;
    f_sel        = P'(1) << j_reg;
    case (state_reg)
      LOAD: begin
        input_ready = 1'b1;
        wr_en_x     = input_valid;
        addr_x      = i_reg;
      end
      CLR:  clear_acc = 1'b1;
      COMP: begin
        addr_x = k_reg;
        addr_w = WW'(int'(g_reg) * N + int'(k_reg));
      end
      OUT:  output_valid = 1'b1;
      default: ;
    endcase
  end

  fc_seq_delay #(
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .din   (issue),
    .dout  (en_acc)
  );

`ifdef FC_SEQ_PERF_EN
  // Saturating count of cycles the output port is held off by backpressure.
  always_ff @(posedge clk) begin
    if (reset) stall_cycles <= '0;
    else if (output_valid && !output_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end

  assign layer_done = (state_reg == OUT) && output_ready && last_lane && last_group;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench: the bench plays the datapath (x RAM, weight ROMs,
// accumulators) driven only by the DUT control pins, and compares each
// streamed neuron against relu(W*x) computed directly from the stimulus.
module tb_fc_layer_sequencer;

  localparam int M      = 10;
  localparam int N      = 8;
  localparam int T      = 16;
  localparam int P      = 1;
  localparam int PL     = 2;
  localparam int GROUPS = M / P;
  localparam int XW     = $clog2(N);
  localparam int WW     = $clog2(M * N / P);

  logic          clk = 1'b0;
  logic          reset, input_valid, output_ready;
  logic          input_ready, output_valid, wr_en_x, wr_en_w, clear_acc, en_acc;
  logic [XW-1:0] addr_x;
  logic [WW-1:0] addr_w;
  logic [P-1:0]  f_sel;
`ifdef FC_SEQ_PERF_EN
  logic [15:0]   stall_cycles;
  logic          layer_done;
`endif

  always #5 clk = ~clk;

  fc_layer_sequencer #(
    .M(M), .N(N), .T(T), .P(P), .PIPE_LAT(PL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .addr_x       (addr_x),
    .wr_en_x      (wr_en_x),
    .addr_w       (addr_w),
    .wr_en_w      (wr_en_w),
    .clear_acc    (clear_acc),
    .en_acc       (en_acc),
    .f_sel        (f_sel)
`ifdef FC_SEQ_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .layer_done   (layer_done)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int din   = 0;
  int t_first;
  int w_rom [M][N];
  int xv    [N];
  int x_ram [N];
  int acc   [P];
  int hist_ax [64];
  int hist_aw [64];

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  // Reference neuron: relu of the dot product of weight row and stimulus vector.
  function automatic int exp_neuron(input int row);
    int s = 0;
    for (int k = 0; k < N; k++) s += w_rom[row][k] * xv[k];
    return relu(s);
  endfunction

  // Datapath emulation for the current cycle, driven only by DUT control pins.
  task automatic sample();
    int src, ax, aw, row, col;
    cyc++;
    hist_ax[cyc % 64] = int'(addr_x);
    hist_aw[cyc % 64] = int'(addr_w);
    if (wr_en_x && int'(addr_x) < N) x_ram[int'(addr_x)] = din;
    if (clear_acc) for (int l = 0; l < P; l++) acc[l] = 0;
    if (en_acc && cyc >= PL) begin
      src = (cyc - PL) % 64;
      ax  = hist_ax[src];
      aw  = hist_aw[src];
      for (int l = 0; l < P; l++) begin
        row = (aw / N) * P + l;
        col = aw % N;
        if (ax < N && row < M) acc[l] += x_ram[ax] * w_rom[row][col];
      end
    end
    if (!reset) check1("clr_en_exclusive", clear_acc & en_acc, 1'b0);
  endtask

  task automatic cyc_begin(input logic iv, input logic ordy);
    input_valid  = iv;
    output_ready = ordy;
    #2;
    sample();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vector(input bit bubble);
    int idx = 0;
    int budget = 0;
    logic iv;
    for (int k = 0; k < N; k++) xv[k] = int'($urandom_range(15));
    while (idx < N && budget < 200) begin
      iv  = bubble ? ((budget % 3) == 0) : 1'b1;
      din = xv[idx];
      cyc_begin(iv, 1'b0);
      check1("load_ready", input_ready, 1'b1);
      check1("load_wr_en_x", wr_en_x, iv);
      if (iv) begin
        check("load_addr_x", int'(addr_x), idx);
        idx++;
      end
      cyc_end();
      budget++;
    end
    check("load_count", idx, N);
  endtask

  task automatic run_group(input int g, input int stall_lane, input int stall_len);
    cyc_begin(1'($urandom_range(1)), 1'b1);
    check1("clr_pulse", clear_acc, 1'b1);
    check1("clr_ready", input_ready, 1'b0);
    check1("clr_wr_en_x", wr_en_x, 1'b0);
    cyc_end();
    for (int off = 1; off <= N + PL; off++) begin
      cyc_begin(1'($urandom_range(1)), 1'b1);
      if (off <= N) begin
        check("comp_addr_x", int'(addr_x), off - 1);
        check("comp_addr_w", int'(addr_w), g * N + off - 1);
      end
      check1("en_acc_window", en_acc, off >= 1 + PL);
      check1("busy_valid", output_valid, 1'b0);
      check1("busy_wr_en_x", wr_en_x, 1'b0);
      cyc_end();
    end
    for (int l = 0; l < P; l++) begin
      if (l == stall_lane) begin
        for (int s = 0; s < stall_len; s++) begin
          cyc_begin(1'b0, 1'b0);
          check1("stall_valid", output_valid, 1'b1);
          check("stall_f_sel", int'(f_sel), 1 << l);
          check1("stall_en_acc", en_acc, 1'b0);
          cyc_end();
        end
      end
      cyc_begin(1'b0, 1'b1);
      check1("out_valid", output_valid, 1'b1);
      check("out_f_sel", int'(f_sel), 1 << l);
      check("neuron_result", relu(acc[l]), exp_neuron(g * P + l));
`ifdef FC_SEQ_PERF_EN
      check1("layer_done", layer_done, (g == GROUPS - 1) && (l == P - 1));
`endif
      $display("neuron %0d: result=%0d expected=%0d", g * P + l, relu(acc[l]), exp_neuron(g * P + l));
      cyc_end();
    end
  endtask

  task automatic run_layer(input bit bubble, input int stall_out, input int stall_len);
    load_vector(bubble);
    t_first = cyc + 1;
    for (int g = 0; g < GROUPS; g++)
      run_group(g, (g == stall_out / P) ? stall_out % P : -1, stall_len);
    cyc_begin(1'b0, 1'b0);
    check1("layer_end_ready", input_ready, 1'b1);
    check1("layer_end_valid", output_valid, 1'b0);
    check("layer_cycles", cyc - t_first, GROUPS * (1 + N + PL + P) + stall_len);
    cyc_end();
  endtask

  initial begin
    for (int r = 0; r < M; r++)
      for (int k = 0; k < N; k++)
        w_rom[r][k] = int'($urandom_range(15)) - 8;

    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      cyc_begin(1'b0, 1'b0);
      cyc_end();
    end
    reset = 1'b0;

    // Reset state.
    cyc_begin(1'b0, 1'b0);
    check1("rst_input_ready", input_ready, 1'b1);
    check1("rst_output_valid", output_valid, 1'b0);
    check1("rst_wr_en_x", wr_en_x, 1'b0);
    check1("rst_wr_en_w", wr_en_w, 1'b0);
    check1("rst_clear_acc", clear_acc, 1'b0);
    check1("rst_en_acc", en_acc, 1'b0);
    check("rst_addr_x", int'(addr_x), 0);
    check("rst_addr_w", int'(addr_w), 0);
    check("rst_f_sel", int'(f_sel), 1);
    cyc_end();

    // Full layer, no bubbles, no backpressure.
    run_layer(1'b0, -1, 0);

    // Bubbled input, 5 cycles of backpressure on output 3.
    run_layer(1'b1, 3, 5);
`ifdef FC_SEQ_PERF_EN
    check("stall_cycles", int'(stall_cycles), 5);
`endif

    // Abort in the compute phase of group 4.
    load_vector(1'b0);
    for (int g = 0; g < 4; g++) run_group(g, -1, 0);
    cyc_begin(1'b0, 1'b1);
    check1("abort_clr", clear_acc, 1'b1);
    cyc_end();
    for (int c = 0; c < 3; c++) begin
      cyc_begin(1'b0, 1'b1);
      cyc_end();
    end
    reset = 1'b1;
    cyc_begin(1'b0, 1'b1);
    cyc_end();
    reset = 1'b0;
    cyc_begin(1'b0, 1'b0);
    check1("abort_input_ready", input_ready, 1'b1);
    check1("abort_en_acc", en_acc, 1'b0);
    check1("abort_output_valid", output_valid, 1'b0);
    check1("abort_clear_acc", clear_acc, 1'b0);
    cyc_end();
    cyc_begin(1'b0, 1'b0);
    check1("abort_en_acc_late", en_acc, 1'b0);
    cyc_end();

    // Fresh vector after the abort yields a correct full layer.
    run_layer(1'b0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
